fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline. Holds the program counter and issues one-outstanding-request fetches to instruction memory over a req/ready + rvalid handshake. Absorbs decode stalls in a one-entry hold buffer and discards in-flight fetches on a branch/jump redirect. Drives the fetch/decode pipeline register consumed by the decode stage: instruction, PC, PC+4 and a valid flag.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch FSM,
// one-entry decode-stall hold buffer and the fetch/decode pipeline register.
module fetch_stage #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_dec,
    input  logic                   i_flush_dec,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_pc_target,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_ready,
    input  logic                   i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic                   o_valid
);

    localparam logic [INSTR_WIDTH-1:0] NOP  = INSTR_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0]  FOUR = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic                   discard_reg, discard_next;
    logic [INSTR_WIDTH-1:0] hold_instr_reg, hold_instr_next;
    logic [ADDR_WIDTH-1:0]  hold_pc_reg, hold_pc_next;
    logic [INSTR_WIDTH-1:0] fd_instr_reg, fd_instr_next;
    logic [ADDR_WIDTH-1:0]  fd_pc_reg, fd_pc_next;
    logic [ADDR_WIDTH-1:0]  fd_pc4_reg, fd_pc4_next;
    logic                   fd_valid_reg, fd_valid_next;

    // Instruction offered to the F/D register this cycle (fresh response or buffer).
    logic                   avail;
    logic [INSTR_WIDTH-1:0] avail_instr;
    logic [ADDR_WIDTH-1:0]  avail_pc;

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            discard_reg    <= 1'b0;
            hold_instr_reg <= NOP;
            hold_pc_reg    <= '0;
            fd_instr_reg   <= NOP;
            fd_pc_reg      <= '0;
            fd_pc4_reg     <= '0;
            fd_valid_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            discard_reg    <= discard_next;
            hold_instr_reg <= hold_instr_next;
            hold_pc_reg    <= hold_pc_next;
            fd_instr_reg   <= fd_instr_next;
            fd_pc_reg      <= fd_pc_next;
            fd_pc4_reg     <= fd_pc4_next;
            fd_valid_reg   <= fd_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        discard_next    = discard_reg;
        hold_instr_next = hold_instr_reg;
        hold_pc_next    = hold_pc_reg;
        avail           = 1'b0;
        avail_instr     = hold_instr_reg;
        avail_pc        = hold_pc_reg;

        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (i_imem_ready) begin
                    state_next = WAIT;
                    // The accepted request still targets the old address.
                    if (i_redirect) discard_next = 1'b1;
                end
            end
            WAIT: begin
                if (i_imem_rvalid) begin
                    if (discard_reg || i_redirect) begin
                        discard_next = 1'b0;
                        state_next   = REQ;
                    end else begin
                        pc_next     = pc_reg + FOUR;
                        avail       = 1'b1;
                        avail_instr = i_imem_rdata;
                        avail_pc    = pc_reg;
                        if (i_stall_dec) begin
                            hold_instr_next = i_imem_rdata;
                            hold_pc_next    = pc_reg;
                            state_next      = HOLD;
                        end else begin
                            state_next = REQ;
                        end
                    end
                end else if (i_redirect) begin
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (i_redirect) begin
                    state_next = REQ;
                end else if (!i_stall_dec) begin
                    avail      = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (i_redirect) pc_next = i_pc_target;
    end

    always_comb begin
        fd_instr_next = NOP;
        fd_pc_next    = '0;
        fd_pc4_next   = '0;
        fd_valid_next = 1'b0;
        if (!i_flush_dec) begin
            if (i_stall_dec) begin
                fd_instr_next = fd_instr_reg;
                fd_pc_next    = fd_pc_reg;
                fd_pc4_next   = fd_pc4_reg;
                fd_valid_next = fd_valid_reg;
            end else if (avail) begin
                fd_instr_next = avail_instr;
                fd_pc_next    = avail_pc;
                fd_pc4_next   = avail_pc + FOUR;
                fd_valid_next = 1'b1;
            end
        end
    end

    assign o_imem_req    = (state_reg == REQ);
    assign o_imem_addr   = pc_reg;
    assign o_instruction = fd_instr_reg;
    assign o_pc          = fd_pc_reg;
    assign o_pc_plus4    = fd_pc4_reg;
    assign o_valid       = fd_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall/hold, redirects, backpressure,
// PC wrap and asynchronous reset, against a latency-programmable memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect, ready, rvalid;
    logic [63:0] target;
    logic [31:0] rdata;
    logic        req, valid;
    logic [63:0] addr, pc, pc4;
    logic [31:0] instr;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          lat;
    int          cnt;
    logic [63:0] mem_addr;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h1000)) dut (
        .i_clk(clk), .i_arst(rst_n),
        .i_stall_dec(stall), .i_flush_dec(flush),
        .i_redirect(redirect), .i_pc_target(target),
        .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_ready(ready), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_instruction(instr), .o_pc(pc), .o_pc_plus4(pc4), .o_valid(valid)
    );

    function automatic logic [31:0] f(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-14s observed=%h expected=%h", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the memory model reacts to what happened at that edge.
    task automatic step();
        logic        acc;
        logic [63:0] a;
        acc = req && ready;
        a   = addr;
        @(posedge clk);
        #1;
        if (rvalid) rvalid = 1'b0;
        if (acc) begin
            cnt      = lat;
            mem_addr = a;
        end
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                rvalid = 1'b1;
                rdata  = f(mem_addr);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {63'd0, req},   64'd0);
        chk({tag, "_instr"}, {32'd0, instr}, 64'h13);
        chk({tag, "_pc"},    pc,             64'd0);
        chk({tag, "_pc4"},   pc4,            64'd0);
        chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; target = '0;
        ready = 1'b1; rvalid = 1'b0; rdata = '0; lat = 1; cnt = 0; mem_addr = '0;
        step(); step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Boot: 1-cycle memory, fetches at 0x1000, 0x1004, 0x1008
        step();
        chk("boot_req", {63'd0, req}, 64'd1);
        chk("boot_addr", addr, 64'h1000);
        step();
        chk("wait_req", {63'd0, req}, 64'd0);
        chk("wait_valid", {63'd0, valid}, 64'd0);
        step();
        chk("f1000_valid", {63'd0, valid}, 64'd1);
        chk("f1000_instr", {32'd0, instr}, {32'd0, f(64'h1000)});
        chk("f1000_pc", pc, 64'h1000);
        chk("f1000_pc4", pc4, 64'h1004);
        chk("next_addr", addr, 64'h1004);
        step();
        chk("bubble_valid", {63'd0, valid}, 64'd0);
        chk("bubble_instr", {32'd0, instr}, 64'h13);
        step();
        chk("f1004_pc", pc, 64'h1004);
        chk("f1004_pc4", pc4, 64'h1008);
        chk("next_addr2", addr, 64'h1008);
        step(); step();
        chk("f1008_pc", pc, 64'h1008);
        chk("f1008_instr", {32'd0, instr}, {32'd0, f(64'h1008)});

        // Redirect while the request is unaccepted
        ready = 1'b0; redirect = 1'b1; flush = 1'b1; target = 64'h1FFC;
        step();
        redirect = 1'b0; flush = 1'b0; ready = 1'b1;
        chk("redir_addr", addr, 64'h1FFC);
        chk("redir_bubble", {63'd0, valid}, 64'd0);
        step(); step();
        chk("f1ffc_pc", pc, 64'h1FFC);
        chk("f1ffc_valid", {63'd0, valid}, 64'd1);

        // Decode stall for three cycles across the 0x2000 response
        stall = 1'b1;
        step();
        chk("stall1_pc", pc, 64'h1FFC);
        step();
        chk("hold_noreq", {63'd0, req}, 64'd0);
        chk("stall2_pc", pc, 64'h1FFC);
        step();
        chk("stall3_noreq", {63'd0, req}, 64'd0);
        chk("stall3_valid", {63'd0, valid}, 64'd1);
        stall = 1'b0;
        step();
        chk("rel_pc", pc, 64'h2000);
        chk("rel_pc4", pc4, 64'h2004);
        chk("rel_instr", {32'd0, instr}, {32'd0, f(64'h2000)});
        chk("rel_addr", addr, 64'h2004);
        step();
        chk("once_valid", {63'd0, valid}, 64'd0);
        step();
        chk("f2004_pc", pc, 64'h2004);

        // Redirect in WAIT, 3-cycle memory
        lat = 3;
        step();
        redirect = 1'b1; flush = 1'b1; target = 64'h3000;
        step();
        redirect = 1'b0; flush = 1'b0;
        chk("rw_noreq", {63'd0, req}, 64'd0);
        chk("rw_addr", addr, 64'h3000);
        step();
        chk("rw_wait_valid", {63'd0, valid}, 64'd0);
        step();
        chk("rw_drop_valid", {63'd0, valid}, 64'd0);
        chk("rw_drop_instr", {32'd0, instr}, 64'h13);
        chk("rw_req", {63'd0, req}, 64'd1);
        chk("rw_req_addr", addr, 64'h3000);

        // Redirect + flush in the same cycle as rvalid
        step(); step(); step();
        chk("rv_pending", {63'd0, rvalid}, 64'd1);
        redirect = 1'b1; flush = 1'b1; target = 64'h4000;
        step();
        redirect = 1'b0; flush = 1'b0;
        chk("rr_valid", {63'd0, valid}, 64'd0);
        chk("rr_instr", {32'd0, instr}, 64'h13);
        chk("rr_pc", pc, 64'd0);
        chk("rr_req", {63'd0, req}, 64'd1);
        chk("rr_addr", addr, 64'h4000);

        // Ready backpressure with a redirect in the middle
        lat = 1; ready = 1'b0;
        step();
        chk("bp1_req", {63'd0, req}, 64'd1);
        chk("bp1_addr", addr, 64'h4000);
        step();
        chk("bp2_addr", addr, 64'h4000);
        redirect = 1'b1; flush = 1'b1; target = 64'h5000;
        step();
        redirect = 1'b0; flush = 1'b0;
        chk("bp3_req", {63'd0, req}, 64'd1);
        chk("bp3_addr", addr, 64'h5000);
        step();
        chk("bp4_addr", addr, 64'h5000);
        ready = 1'b1;
        step();
        chk("bp_acc_req", {63'd0, req}, 64'd0);
        step();
        chk("f5000_pc", pc, 64'h5000);
        chk("f5000_instr", {32'd0, instr}, {32'd0, f(64'h5000)});

        // Redirect on an accepted request, then PC wrap
        redirect = 1'b1; flush = 1'b1; target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect = 1'b0; flush = 1'b0;
        chk("ra_noreq", {63'd0, req}, 64'd0);
        chk("ra_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("ra_drop_valid", {63'd0, valid}, 64'd0);
        chk("ra_req", {63'd0, req}, 64'd1);
        step(); step();
        chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc4", pc4, 64'd0);
        chk("wrap_valid", {63'd0, valid}, 64'd1);
        chk("wrap_addr", addr, 64'd0);

        // Asynchronous reset while a fetch is outstanding
        stall = 1'b1;
        step();
        chk("pre_rst_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pre_rst_noreq", {63'd0, req}, 64'd0);
        rst_n = 1'b0;
        #1;
        rvalid = 1'b0; cnt = 0; stall = 1'b0;
        chk_reset_outputs("arst");
        chk("arst_addr", addr, 64'h1000);
        step();
        rst_n = 1'b1;
        step();
        chk("reboot_req", {63'd0, req}, 64'd1);
        chk("reboot_addr", addr, 64'h1000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
